// File: rtl/bsg_manycore_mem_responder_pkg.sv
// Shared types and constants for the manycore memory responder.
// The optional atomic path is enabled with BSG_MANYCORE_MEM_RESPONDER_AMO_EN.
package bsg_manycore_mem_responder_pkg;

    // Controller states; S_WB is only reachable when atomics are compiled in.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WB     = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    // Forward-packet opcodes.
    typedef enum logic [1:0] {
        e_remote_load  = 2'd0,
        e_remote_store = 2'd1,
        e_remote_amo   = 2'd2,
        e_remote_rsvd  = 2'd3
    } op_e;

    // Return-packet types.
    typedef enum logic [1:0] {
        e_return_credit = 2'd0,
        e_return_int_wb = 2'd1
    } return_e;

    // AMO sub-operations carried in op_ex.
    localparam logic [3:0] AMO_SWAP = 4'd0;
    localparam logic [3:0] AMO_OR   = 4'd1;

    // Decoded request class, latched when the request leaves the FIFO.
    typedef enum logic [2:0] {
        K_LOAD       = 3'd0,
        K_STORE      = 3'd1,
        K_AMO_SWAP   = 3'd2,
        K_AMO_OR     = 3'd3,
        K_OOR_WB     = 3'd4,  // bad address on a load/amo: int_wb with poison data
        K_OOR_CREDIT = 3'd5   // bad address on a store, or unsupported op
    } kind_e;

    localparam logic [31:0] DEAD_BEEF         = 32'hDEAD_BEEF;
    localparam int          ERROR_COUNT_WIDTH = 16;

    // New memory value written back by an atomic.
    function automatic logic [31:0] amo_result(input kind_e kind,
                                               input logic [31:0] old_val,
                                               input logic [31:0] operand);
        logic [31:0] result;
        result = operand;
        if (kind == K_AMO_OR) begin
            result = old_val | operand;
        end
        return result;
    endfunction

endpackage

// File: rtl/bsg_manycore_mem_responder_sram.sv
// Single-port, synchronous-read word SRAM with byte write mask.
// Each byte lane is its own array so the masked write maps onto plain RAM.
module bsg_manycore_mem_responder_sram #(
    parameter int els_p     = 1024,
    parameter int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                 clk_i,
    input  logic                 v_i,
    input  logic                 w_i,
    input  logic [lg_els_lp-1:0] addr_i,
    input  logic [31:0]          data_i,
    input  logic [3:0]           mask_i,
    output logic [31:0]          data_o
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [els_p];
            logic [7:0] rd_q;

            // Byte lane: masked write, otherwise a registered read.
            always_ff @(posedge clk_i) begin
                if (v_i && w_i && mask_i[gi]) begin
                    mem[addr_i] <= data_i[8*gi +: 8];
                end else if (v_i && !w_i) begin
                    rd_q <= mem[addr_i];
                end
            end

            assign data_o[8*gi +: 8] = rd_q;
        end
    endgenerate

endmodule

// File: rtl/bsg_manycore_mem_responder.sv
// Cache-link endpoint: executes remote loads/stores against a local word SRAM
// and returns exactly one response per request. One request in flight.
// Define BSG_MANYCORE_MEM_RESPONDER_AMO_EN to add amoswap/amoor support.
//
// Forward packet (MSB..LSB): addr, op, op_ex[3:0], reg_id, payload[31:0], src_y, src_x
// Return packet  (MSB..LSB): type, data[31:0], load_id, src_y, src_x, dest_y, dest_x
// link_sif_i: {fwd_v, fwd_data, rev_ready_and}
// link_sif_o: {rev_v, zero pad, rev_data, fwd_ready_and}
module bsg_manycore_mem_responder
    import bsg_manycore_mem_responder_pkg::*;
#(
    parameter int addr_width_p      = 12,
    parameter int data_width_p      = 32,
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 4,
    parameter int load_id_width_p   = 5,
    parameter int els_p             = 1024,
    parameter int lg_els_lp         = (els_p > 1) ? $clog2(els_p) : 1,
    parameter int link_sif_width_lp = 2 +
        (((addr_width_p + 6 + load_id_width_p + data_width_p + y_cord_width_p + x_cord_width_p) >
          (2 + data_width_p + load_id_width_p + 2*y_cord_width_p + 2*x_cord_width_p))
         ? (addr_width_p + 6 + load_id_width_p + data_width_p + y_cord_width_p + x_cord_width_p)
         : (2 + data_width_p + load_id_width_p + 2*y_cord_width_p + 2*x_cord_width_p))
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [link_sif_width_lp-1:0] link_sif_i,
    output logic [link_sif_width_lp-1:0] link_sif_o,
    input  logic [x_cord_width_p-1:0]    my_x_i,
    input  logic [y_cord_width_p-1:0]    my_y_i
);

    localparam int PAY_LO  = x_cord_width_p + y_cord_width_p;
    localparam int ID_LO   = PAY_LO + data_width_p;
    localparam int OPEX_LO = ID_LO + load_id_width_p;
    localparam int OP_LO   = OPEX_LO + 4;
    localparam int ADDR_LO = OP_LO + 2;
    localparam int FWD_W   = ADDR_LO + addr_width_p;
    localparam int RET_W   = 2 + data_width_p + load_id_width_p + 2*y_cord_width_p + 2*x_cord_width_p;

    // ---------------- link unpacking ----------------
    logic             fwd_v;
    logic [FWD_W-1:0] fwd_data;
    logic             rev_ready;

    assign fwd_v     = link_sif_i[link_sif_width_lp-1];
    assign fwd_data  = link_sif_i[FWD_W:1];
    assign rev_ready = link_sif_i[0];

    // ---------------- two-entry input FIFO ----------------
    logic [FWD_W-1:0] fifo_mem_q [2];
    logic [FWD_W-1:0] fifo_mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             fwd_ready_q, fwd_ready_d;
    logic             push, pop, fifo_v;
    logic [FWD_W-1:0] head;

    assign push   = fwd_v && fwd_ready_q;
    assign fifo_v = (count_q != 2'd0);
    assign head   = fifo_mem_q[rd_ptr_q];

    // FIFO bookkeeping; ready is registered so it reads 0 throughout reset.
    always_comb begin
        fifo_mem_d[0] = fifo_mem_q[0];
        fifo_mem_d[1] = fifo_mem_q[1];
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = fwd_data;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d     = count_q + {1'b0, push} - {1'b0, pop};
        fwd_ready_d = (count_d != 2'd2);
    end

    // ---------------- head-of-FIFO decode ----------------
    logic [addr_width_p-1:0]    head_addr;
    logic [1:0]                 head_op;
    logic [3:0]                 head_opex;
    logic [load_id_width_p-1:0] head_id;
    logic [data_width_p-1:0]    head_pay;
    logic [y_cord_width_p-1:0]  head_sy;
    logic [x_cord_width_p-1:0]  head_sx;
    logic [lg_els_lp-1:0]       head_idx;
    logic                       head_in_range;
    kind_e                      head_kind;

    assign head_addr = head[ADDR_LO +: addr_width_p];
    assign head_op   = head[OP_LO +: 2];
    assign head_opex = head[OPEX_LO +: 4];
    assign head_id   = head[ID_LO +: load_id_width_p];
    assign head_pay  = head[PAY_LO +: data_width_p];
    assign head_sy   = head[x_cord_width_p +: y_cord_width_p];
    assign head_sx   = head[0 +: x_cord_width_p];
    assign head_idx  = head_addr[lg_els_lp-1:0];

    generate
        if (addr_width_p > lg_els_lp) begin : g_hi_addr
            assign head_in_range = (head_addr[addr_width_p-1:lg_els_lp] == '0);
        end else begin : g_no_hi_addr
            assign head_in_range = 1'b1;
        end
    endgenerate

    // Classify the request; anything we cannot execute becomes a credit.
    always_comb begin
        head_kind = K_OOR_CREDIT;
        case (head_op)
            e_remote_load:  head_kind = head_in_range ? K_LOAD  : K_OOR_WB;
            e_remote_store: head_kind = head_in_range ? K_STORE : K_OOR_CREDIT;
`ifdef BSG_MANYCORE_MEM_RESPONDER_AMO_EN
            e_remote_amo: begin
                if (head_opex == AMO_SWAP) begin
                    head_kind = head_in_range ? K_AMO_SWAP : K_OOR_WB;
                end else if (head_opex == AMO_OR) begin
                    head_kind = head_in_range ? K_AMO_OR : K_OOR_WB;
                end else begin
                    head_kind = K_OOR_CREDIT;
                end
            end
`endif
            default:        head_kind = K_OOR_CREDIT;
        endcase
    end

    // ---------------- controller ----------------
    state_e                         state_q, state_d;
    kind_e                          kind_q, kind_d;
    logic [load_id_width_p-1:0]     id_q, id_d;
    logic [y_cord_width_p-1:0]      sy_q, sy_d;
    logic [x_cord_width_p-1:0]      sx_q, sx_d;
    logic [data_width_p-1:0]        resp_data_q, resp_data_d;
    logic [ERROR_COUNT_WIDTH-1:0]   error_count_q, error_count_d;
`ifdef BSG_MANYCORE_MEM_RESPONDER_AMO_EN
    logic [lg_els_lp-1:0]           idx_q, idx_d;
    logic [data_width_p-1:0]        pay_q, pay_d;
`endif

    logic                 sram_v, sram_w;
    logic [lg_els_lp-1:0] sram_addr;
    logic [31:0]          sram_wdata, sram_rdata;
    logic [3:0]           sram_mask;

    // Next-state logic; the SRAM is driven only in IDLE (request) or WB (AMO update).
    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        id_d          = id_q;
        sy_d          = sy_q;
        sx_d          = sx_q;
        resp_data_d   = resp_data_q;
        error_count_d = error_count_q;
`ifdef BSG_MANYCORE_MEM_RESPONDER_AMO_EN
        idx_d         = idx_q;
        pay_d         = pay_q;
`endif
        pop        = 1'b0;
        sram_v     = 1'b0;
        sram_w     = 1'b0;
        sram_addr  = head_idx;
        sram_wdata = head_pay;
        sram_mask  = head_opex;

        case (state_q)
            S_IDLE: begin
                if (fifo_v) begin
                    pop     = 1'b1;
                    kind_d  = head_kind;
                    id_d    = head_id;
                    sy_d    = head_sy;
                    sx_d    = head_sx;
`ifdef BSG_MANYCORE_MEM_RESPONDER_AMO_EN
                    idx_d   = head_idx;
                    pay_d   = head_pay;
`endif
                    sram_v  = (head_kind inside {K_LOAD, K_STORE, K_AMO_SWAP, K_AMO_OR});
                    sram_w  = (head_kind == K_STORE);
                    if ((head_kind inside {K_OOR_WB, K_OOR_CREDIT}) &&
                        (error_count_q != {ERROR_COUNT_WIDTH{1'b1}})) begin
                        error_count_d = error_count_q + 1'b1;
                    end
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                case (kind_q)
                    K_LOAD, K_AMO_SWAP, K_AMO_OR: resp_data_d = sram_rdata;
                    K_OOR_WB:                     resp_data_d = DEAD_BEEF;
                    default:                      resp_data_d = '0;
                endcase
                state_d = S_RESP;
`ifdef BSG_MANYCORE_MEM_RESPONDER_AMO_EN
                if (kind_q inside {K_AMO_SWAP, K_AMO_OR}) begin
                    state_d = S_WB;
                end
`endif
            end
            S_WB: begin
`ifdef BSG_MANYCORE_MEM_RESPONDER_AMO_EN
                sram_v     = 1'b1;
                sram_w     = 1'b1;
                sram_mask  = 4'hF;
                sram_addr  = idx_q;
                sram_wdata = amo_result(kind_q, resp_data_q, pay_q);
                state_d    = S_RESP;
`else
                state_d    = S_IDLE;
`endif
            end
            S_RESP: begin
                if (rev_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // All state clears the moment reset is asserted.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            fwd_ready_q   <= 1'b0;
            state_q       <= S_IDLE;
            kind_q        <= K_LOAD;
            id_q          <= '0;
            sy_q          <= '0;
            sx_q          <= '0;
            resp_data_q   <= '0;
            error_count_q <= '0;
`ifdef BSG_MANYCORE_MEM_RESPONDER_AMO_EN
            idx_q         <= '0;
            pay_q         <= '0;
`endif
        end else begin
            fifo_mem_q[0] <= fifo_mem_d[0];
            fifo_mem_q[1] <= fifo_mem_d[1];
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            fwd_ready_q   <= fwd_ready_d;
            state_q       <= state_d;
            kind_q        <= kind_d;
            id_q          <= id_d;
            sy_q          <= sy_d;
            sx_q          <= sx_d;
            resp_data_q   <= resp_data_d;
            error_count_q <= error_count_d;
`ifdef BSG_MANYCORE_MEM_RESPONDER_AMO_EN
            idx_q         <= idx_d;
            pay_q         <= pay_d;
`endif
        end
    end

    bsg_manycore_mem_responder_sram #(
        .els_p     (els_p),
        .lg_els_lp (lg_els_lp)
    ) sram (
        .clk_i  (clk_i),
        .v_i    (sram_v),
        .w_i    (sram_w),
        .addr_i (sram_addr),
        .data_i (sram_wdata),
        .mask_i (sram_mask),
        .data_o (sram_rdata)
    );

    // ---------------- response packing ----------------
    logic             rev_v;
    logic [1:0]       ret_type;
    logic [RET_W-1:0] ret_pkt;

    assign rev_v    = (state_q == S_RESP);
    assign ret_type = (kind_q inside {K_LOAD, K_AMO_SWAP, K_AMO_OR, K_OOR_WB})
                      ? 2'(e_return_int_wb) : 2'(e_return_credit);
    assign ret_pkt  = {ret_type, resp_data_q, id_q, my_y_i, my_x_i, sy_q, sx_q};

    // Assemble the outgoing link word; bits not carried by the return packet are zero.
    always_comb begin
        link_sif_o                        = '0;
        link_sif_o[link_sif_width_lp-1]   = rev_v;
        link_sif_o[RET_W:1]               = ret_pkt;
        link_sif_o[0]                     = fwd_ready_q;
    end

endmodule

// File: tb/tb_bsg_manycore_mem_responder.sv
// Directed bench for bsg_manycore_mem_responder (default 12-bit address,
// 4-bit coordinates, 5-bit load id, 1024 words).
module tb_bsg_manycore_mem_responder;
    import bsg_manycore_mem_responder_pkg::*;

    localparam int AW = 12, XW = 4, YW = 4, IW = 5, ELS = 1024, LW = 65;
    localparam logic [3:0] MY_X = 4'h3;
    localparam logic [3:0] MY_Y = 4'h7;
    localparam logic [1:0] OP_LD = 2'd0, OP_ST = 2'd1, OP_AMO = 2'd2, OP_BAD = 2'd3;
    localparam logic [1:0] RT_CR = 2'd0, RT_WB = 2'd1;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          fwd_v_tb;
    logic [62:0]   fwd_data_tb;
    logic          rev_ready_tb;
    logic [LW-1:0] link_i, link_o;
    logic          rev_v, fwd_ready;
    logic [54:0]   ret;

    int chk_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    assign link_i    = {fwd_v_tb, fwd_data_tb, rev_ready_tb};
    assign rev_v     = link_o[LW-1];
    assign ret       = link_o[55:1];
    assign fwd_ready = link_o[0];

    bsg_manycore_mem_responder #(
        .addr_width_p    (AW),
        .data_width_p    (32),
        .x_cord_width_p  (XW),
        .y_cord_width_p  (YW),
        .load_id_width_p (IW),
        .els_p           (ELS)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .link_sif_i (link_i),
        .link_sif_o (link_o),
        .my_x_i     (MY_X),
        .my_y_i     (MY_Y)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [62:0] mk_req(input logic [1:0] op, input logic [3:0] opex,
                                           input logic [11:0] addr, input logic [4:0] id,
                                           input logic [31:0] pay, input logic [3:0] sx,
                                           input logic [3:0] sy);
        return {addr, op, opex, id, pay, sy, sx};
    endfunction

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input logic [62:0] pkt);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        fwd_data_tb = pkt;
        fwd_v_tb    = 1'b1;
        while (n < 100 && !done) begin
            if (fwd_ready) done = 1'b1;
            @(negedge clk);
            n++;
        end
        fwd_v_tb = 1'b0;
        check("send_accepted", 64'(done), 64'd1);
    endtask

    // Latency counts negedges from the one right after the transfer (that one is 1).
    task automatic recv(output logic [54:0] pkt, output int lat);
        int n;
        bit seen;
        n = 1;
        seen = 1'b0;
        pkt = '0;
        while (n <= 100 && !seen) begin
            if (rev_v) begin
                seen = 1'b1;
                pkt  = ret;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        lat = n;
        check("resp_seen", 64'(seen), 64'd1);
        if (seen) begin
            $display("resp id=%0d type=%0d data=%h lat=%0d", pkt[20:16], pkt[54:53], pkt[52:21], lat);
            @(negedge clk);
        end
    endtask

    task automatic txn(input string tag, input logic [1:0] op, input logic [3:0] opex,
                       input logic [11:0] addr, input logic [4:0] id, input logic [31:0] pay,
                       input logic [3:0] sx, input logic [3:0] sy,
                       input logic [1:0] etype, input logic [31:0] edata, input int elat);
        logic [54:0] r;
        int          lat;
        send(mk_req(op, opex, addr, id, pay, sx, sy));
        recv(r, lat);
        check({tag, ".type"},   64'(r[54:53]), 64'(etype));
        check({tag, ".data"},   64'(r[52:21]), 64'(edata));
        check({tag, ".id"},     64'(r[20:16]), 64'(id));
        check({tag, ".src_y"},  64'(r[15:12]), 64'(MY_Y));
        check({tag, ".src_x"},  64'(r[11:8]),  64'(MY_X));
        check({tag, ".dest_y"}, 64'(r[7:4]),   64'(sy));
        check({tag, ".dest_x"}, 64'(r[3:0]),   64'(sx));
        check({tag, ".lat"},    64'(lat),      64'(elat));
    endtask

    logic [31:0] exp_data [4];
    logic [1:0]  exp_type [4];

    initial begin
        reset_i      = 1'b1;
        fwd_v_tb     = 1'b0;
        fwd_data_tb  = '0;
        rev_ready_tb = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst.fwd_ready", 64'(fwd_ready), 64'd0);
        check("rst.rev_v", 64'(rev_v), 64'd0);
        check("rst.state", 64'(dut.state_q), 64'(S_IDLE));
        check("rst.err", 64'(dut.error_count_q), 64'd0);
        reset_i = 1'b0;
        repeat (2) @(negedge clk);
        check("idle.fwd_ready", 64'(fwd_ready), 64'd1);

        // 1: full-word store then load
        txn("st5", OP_ST, 4'hF, 12'd5, 5'd3, 32'h1234_5678, 4'h2, 4'h1, RT_CR, 32'h0, 3);
        txn("ld5", OP_LD, 4'h0, 12'd5, 5'd9, 32'h0, 4'h2, 4'h1, RT_WB, 32'h1234_5678, 3);

        // 2: byte-masked store over zero; then an all-zero mask must not write
        txn("st6z", OP_ST, 4'hF, 12'd6, 5'd1, 32'h0, 4'h5, 4'h6, RT_CR, 32'h0, 3);
        txn("st6m", OP_ST, 4'b0101, 12'd6, 5'd2, 32'hAABB_CCDD, 4'h5, 4'h6, RT_CR, 32'h0, 3);
        txn("ld6", OP_LD, 4'h0, 12'd6, 5'd4, 32'h0, 4'h5, 4'h6, RT_WB, 32'h00BB_00DD, 3);
        txn("st5m0", OP_ST, 4'h0, 12'd5, 5'd5, 32'hFFFF_FFFF, 4'h1, 4'h2, RT_CR, 32'h0, 3);
        txn("ld5b", OP_LD, 4'h0, 12'd5, 5'd6, 32'h0, 4'h1, 4'h2, RT_WB, 32'h1234_5678, 3);

        // 3: out-of-range and unsupported requests
        txn("ldoor", OP_LD, 4'h0, 12'd1024, 5'd7, 32'h0, 4'h9, 4'hA, RT_WB, 32'hDEAD_BEEF, 3);
        check("err1", 64'(dut.error_count_q), 64'd1);
        txn("stoor", OP_ST, 4'hF, 12'd1029, 5'd8, 32'hCAFE_F00D, 4'h9, 4'hA, RT_CR, 32'h0, 3);
        txn("badop", OP_BAD, 4'hF, 12'd5, 5'd10, 32'hCAFE_F00D, 4'h9, 4'hA, RT_CR, 32'h0, 3);
        check("err3", 64'(dut.error_count_q), 64'd3);
        txn("ld5c", OP_LD, 4'h0, 12'd5, 5'd11, 32'h0, 4'h9, 4'hA, RT_WB, 32'h1234_5678, 3);

        // 4: reverse-channel backpressure with four requests
        rev_ready_tb = 1'b0;
        send(mk_req(OP_LD, 4'h0, 12'd5, 5'd1, 32'h0, 4'h2, 4'h1));
        send(mk_req(OP_LD, 4'h0, 12'd6, 5'd2, 32'h0, 4'h2, 4'h1));
        send(mk_req(OP_LD, 4'h0, 12'd1024, 5'd3, 32'h0, 4'h2, 4'h1));
        begin
            bit rdy_seen;
            rdy_seen    = 1'b0;
            fwd_data_tb = mk_req(OP_ST, 4'hF, 12'd7, 5'd4, 32'h77, 4'h2, 4'h1);
            fwd_v_tb    = 1'b1;
            for (int i = 0; i < 10; i++) begin
                if (fwd_ready) rdy_seen = 1'b1;
                @(negedge clk);
            end
            check("bp.fwd_ready", 64'(rdy_seen), 64'd0);
            check("bp.rev_v", 64'(rev_v), 64'd1);
            check("bp.state", 64'(dut.state_q), 64'(S_RESP));
        end
        exp_data[0] = 32'h1234_5678; exp_type[0] = RT_WB;
        exp_data[1] = 32'h00BB_00DD; exp_type[1] = RT_WB;
        exp_data[2] = 32'hDEAD_BEEF; exp_type[2] = RT_WB;
        exp_data[3] = 32'h0;         exp_type[3] = RT_CR;
        rev_ready_tb = 1'b1;
        fork
            send(mk_req(OP_ST, 4'hF, 12'd7, 5'd4, 32'h77, 4'h2, 4'h1));
            begin
                logic [54:0] r;
                int          lat;
                for (int i = 0; i < 4; i++) begin
                    recv(r, lat);
                    check("bp.id", 64'(r[20:16]), 64'(i + 1));
                    check("bp.data", 64'(r[52:21]), 64'(exp_data[i]));
                    check("bp.type", 64'(r[54:53]), 64'(exp_type[i]));
                end
            end
        join
        check("err4", 64'(dut.error_count_q), 64'd4);

        // 5: asynchronous reset while a request is in ACCESS and another is queued
        send(mk_req(OP_LD, 4'h0, 12'd5, 5'd5, 32'h0, 4'h2, 4'h1));
        send(mk_req(OP_LD, 4'h0, 12'd6, 5'd6, 32'h0, 4'h2, 4'h1));
        check("pre_rst.state", 64'(dut.state_q), 64'(S_ACCESS));
        reset_i = 1'b1;
        #1;
        check("arst.rev_v", 64'(rev_v), 64'd0);
        check("arst.state", 64'(dut.state_q), 64'(S_IDLE));
        check("arst.fwd_ready", 64'(fwd_ready), 64'd0);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        begin
            int resp_seen;
            resp_seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (rev_v) resp_seen++;
            end
            check("arst.no_resp", 64'(resp_seen), 64'd0);
        end
        check("arst.err", 64'(dut.error_count_q), 64'd0);
        txn("st9", OP_ST, 4'hF, 12'd9, 5'd12, 32'h5A5A_1234, 4'h4, 4'h4, RT_CR, 32'h0, 3);
        txn("ld9", OP_LD, 4'h0, 12'd9, 5'd13, 32'h0, 4'h4, 4'h4, RT_WB, 32'h5A5A_1234, 3);

        // 6: atomics
        txn("st10", OP_ST, 4'hF, 12'd10, 5'd14, 32'h0000_00F0, 4'h6, 4'h3, RT_CR, 32'h0, 3);
`ifdef BSG_MANYCORE_MEM_RESPONDER_AMO_EN
        txn("amoor", OP_AMO, 4'd1, 12'd10, 5'd15, 32'h0000_000F, 4'h6, 4'h3, RT_WB, 32'h0000_00F0, 4);
        txn("ld10", OP_LD, 4'h0, 12'd10, 5'd16, 32'h0, 4'h6, 4'h3, RT_WB, 32'h0000_00FF, 3);
        txn("amoswap", OP_AMO, 4'd0, 12'd10, 5'd17, 32'h0000_0011, 4'h6, 4'h3, RT_WB, 32'h0000_00FF, 4);
        txn("ld10b", OP_LD, 4'h0, 12'd10, 5'd18, 32'h0, 4'h6, 4'h3, RT_WB, 32'h0000_0011, 3);
        check("amo.err", 64'(dut.error_count_q), 64'd0);
`else
        txn("amoor", OP_AMO, 4'd1, 12'd10, 5'd15, 32'h0000_000F, 4'h6, 4'h3, RT_CR, 32'h0, 3);
        check("amo.err", 64'(dut.error_count_q), 64'd1);
        txn("ld10", OP_LD, 4'h0, 12'd10, 5'd16, 32'h0, 4'h6, 4'h3, RT_WB, 32'h0000_00F0, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
